// File: rtl/cache_victim_buffer_pkg.sv
// Shared definitions for the write-back victim buffer.
// Holds the drain FSM state type and width helpers.
package cache_victim_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } vb_state_e;

    function automatic int calc_taglen(
        input int pa_bits,
        input int set_len,
        input int off_len
    );
        return pa_bits - set_len - off_len;
    endfunction

    // Beat counter needs at least one bit even for single-beat lines.
    function automatic int calc_cntw(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/cache_victim_buffer_waysel.sv
// Victim way select: lowest-index dirty victim, AND-OR muxed line and tag.
// Ports: i_victim_way, i_dirty_way, i_line_way, i_tag_way -> o_hit, o_line, o_tag.
module cache_victim_waysel #(
    parameter int NUMWAYS = 4,
    parameter int LINELEN = 512,
    parameter int TAGLEN  = 21
) (
    input  logic [NUMWAYS-1:0]         i_victim_way,
    input  logic [NUMWAYS-1:0]         i_dirty_way,
    input  logic [NUMWAYS*LINELEN-1:0] i_line_way,
    input  logic [NUMWAYS*TAGLEN-1:0]  i_tag_way,
    output logic                       o_hit,
    output logic [LINELEN-1:0]         o_line,
    output logic [TAGLEN-1:0]          o_tag
);

    logic [NUMWAYS-1:0] w_cand;
    logic [NUMWAYS-1:0] w_sel;

    assign w_cand = i_victim_way & i_dirty_way;
    // Isolate the lowest set bit so a multi-hot victim still muxes one way.
    assign w_sel  = w_cand & (~w_cand + NUMWAYS'(1));
    assign o_hit  = |w_cand;

    always_comb begin
        o_line = '0;
        o_tag  = '0;
        for (int i = 0; i < NUMWAYS; i++) begin
            o_line = o_line |
                ({LINELEN{w_sel[i]}} & i_line_way[i*LINELEN +: LINELEN]);
            o_tag  = o_tag |
                ({TAGLEN{w_sel[i]}} & i_tag_way[i*TAGLEN +: TAGLEN]);
        end
    end

endmodule

// File: rtl/cache_victim_buffer.sv
// Write-back victim buffer: captures a dirty victim line and drains it beat by beat.
// Ports: capture side (CaptureEn, VictimWay, DirtyWay, ReadDataLineWay, TagWay,
// CacheSet, CaptureReady), lookup (LookupAdr, BufferHit), bus (BusValid, BusReady,
// BusAdr, BusData, BusLast), DrainDone pulse.
module cache_victim_buffer
    import cache_victim_buffer_pkg::*;
#(
    parameter int NUMWAYS   = 4,
    parameter int SETLEN    = 7,
    parameter int OFFSETLEN = 6,
    parameter int PA_BITS   = 34,
    parameter int LINELEN   = 512,
    parameter int BEATLEN   = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  CaptureEn,
    input  logic [NUMWAYS-1:0]    VictimWay,
    input  logic [NUMWAYS-1:0]    DirtyWay,
    input  logic [NUMWAYS*LINELEN-1:0] ReadDataLineWay,
    input  logic [NUMWAYS*calc_taglen(PA_BITS, SETLEN, OFFSETLEN)-1:0] TagWay,
    input  logic [SETLEN-1:0]     CacheSet,
    input  logic [PA_BITS-1:0]    LookupAdr,
    output logic                  CaptureReady,
    output logic                  BufferHit,
    output logic                  BusValid,
    input  logic                  BusReady,
    output logic [PA_BITS-1:0]    BusAdr,
    output logic [BEATLEN-1:0]    BusData,
    output logic                  BusLast,
    output logic                  DrainDone
);

    localparam int TAGLEN    = calc_taglen(PA_BITS, SETLEN, OFFSETLEN);
    localparam int BEATS     = LINELEN / BEATLEN;
    localparam int CNTW      = calc_cntw(BEATS);
    localparam int BEATBYTES = BEATLEN / 8;

    vb_state_e            r_state;
    vb_state_e            w_next;
    logic [CNTW-1:0]      r_cnt;
    logic [LINELEN-1:0]   r_line;
    logic [TAGLEN-1:0]    r_tag;
    logic [SETLEN-1:0]    r_set;
    logic                 r_valid;

    logic                 w_sel_hit;
    logic [LINELEN-1:0]   w_sel_line;
    logic [TAGLEN-1:0]    w_sel_tag;
    logic                 w_capture;
    logic                 w_fire;
    logic                 w_last;
    logic [PA_BITS-1:0]   w_base;
    logic [PA_BITS-1:0]   w_off;
    logic [31:0]          w_bit_idx;
    logic [LINELEN-1:0]   w_shifted;

    cache_victim_waysel #(
        .NUMWAYS (NUMWAYS),
        .LINELEN (LINELEN),
        .TAGLEN  (TAGLEN)
    ) u_waysel (
        .i_victim_way (VictimWay),
        .i_dirty_way  (DirtyWay),
        .i_line_way   (ReadDataLineWay),
        .i_tag_way    (TagWay),
        .o_hit        (w_sel_hit),
        .o_line       (w_sel_line),
        .o_tag        (w_sel_tag)
    );

    assign w_fire = (r_state == DRAIN) && BusReady;
    assign w_last = (r_cnt == CNTW'(BEATS - 1));

    always_comb begin
        w_next       = r_state;
        w_capture    = 1'b0;
        CaptureReady = 1'b0;
        BusValid     = 1'b0;
        DrainDone    = 1'b0;
        unique case (r_state)
            IDLE: begin
                CaptureReady = 1'b1;
                if (CaptureEn && w_sel_hit) begin
                    w_capture = 1'b1;
                    w_next    = DRAIN;
                end
            end
            DRAIN: begin
                BusValid = 1'b1;
                if (w_fire && w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                DrainDone = 1'b1;
                w_next    = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Buffer contents load only on capture; drain just walks the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_line  <= '0;
            r_tag   <= '0;
            r_set   <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_line  <= w_sel_line;
                r_tag   <= w_sel_tag;
                r_set   <= CacheSet;
                r_cnt   <= '0;
                r_valid <= 1'b1;
            end else if (w_fire) begin
                r_cnt <= w_last ? '0 : r_cnt + CNTW'(1);
                if (w_last) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign w_base    = {r_tag, r_set, {OFFSETLEN{1'b0}}};
    assign w_off     = PA_BITS'(r_cnt) * PA_BITS'(BEATBYTES);
    assign w_bit_idx = 32'(r_cnt) * 32'(BEATLEN);
    assign w_shifted = r_line >> w_bit_idx;

    assign BusAdr  = BusValid ? (w_base + w_off) : '0;
    assign BusData = BusValid ? w_shifted[BEATLEN-1:0] : '0;
    assign BusLast = BusValid && w_last;

    assign BufferHit = r_valid &&
        (LookupAdr[PA_BITS-1:OFFSETLEN] == {r_tag, r_set});

endmodule

// File: tb/tb_cache_victim_buffer.sv
// Scoreboard bench for cache_victim_buffer.
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_cache_victim_buffer;

    localparam int NW    = 4;
    localparam int SL    = 7;
    localparam int OL    = 6;
    localparam int PA    = 34;
    localparam int LL    = 512;
    localparam int BL    = 64;
    localparam int TL    = PA - SL - OL;
    localparam int BEATS = LL / BL;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              CaptureEn = 1'b0;
    logic [NW-1:0]     VictimWay = '0;
    logic [NW-1:0]     DirtyWay = '0;
    logic [NW*LL-1:0]  ReadDataLineWay = '0;
    logic [NW*TL-1:0]  TagWay = '0;
    logic [SL-1:0]     CacheSet = '0;
    logic [PA-1:0]     LookupAdr = '0;
    logic              BusReady = 1'b0;
    logic              CaptureReady;
    logic              BufferHit;
    logic              BusValid;
    logic [PA-1:0]     BusAdr;
    logic [BL-1:0]     BusData;
    logic              BusLast;
    logic              DrainDone;

    cache_victim_buffer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .CaptureEn       (CaptureEn),
        .VictimWay       (VictimWay),
        .DirtyWay        (DirtyWay),
        .ReadDataLineWay (ReadDataLineWay),
        .TagWay          (TagWay),
        .CacheSet        (CacheSet),
        .LookupAdr       (LookupAdr),
        .CaptureReady    (CaptureReady),
        .BufferHit       (BufferHit),
        .BusValid        (BusValid),
        .BusReady        (BusReady),
        .BusAdr          (BusAdr),
        .BusData         (BusData),
        .BusLast         (BusLast),
        .DrainDone       (DrainDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PA-1:0] adr;
        logic [BL-1:0] data;
        logic          last;
    } beat_t;

    beat_t          exp_q[$];
    beat_t          e;
    beat_t          held;
    int             n_checks = 0;
    int             n_fail = 0;
    int             done_cnt = 0;
    int             acc_cnt = 0;
    bit             m_valid = 0;
    logic [PA-OL-1:0] m_id = '0;
    bit             prev_done = 0;
    bit             held_v = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rand_ways();
        logic [95:0] t;
        for (int i = 0; i < NW * LL / 32; i++)
            ReadDataLineWay[i*32 +: 32] = $urandom;
        t = {$urandom, $urandom, $urandom};
        TagWay = t[NW*TL-1:0];
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            chk(BufferHit == (m_valid && LookupAdr[PA-1:OL] == m_id),
                "buffer_hit", 64'(BufferHit), 64'(m_valid));
            if (prev_done)
                chk(!DrainDone && CaptureReady, "done_pulse",
                    {DrainDone, CaptureReady}, 64'b01);
            prev_done = DrainDone;
            if (DrainDone) begin
                chk(exp_q.size() == 0, "drain_complete", exp_q.size(), 0);
                done_cnt++;
            end
            if (BusValid) begin
                if (held_v)
                    chk(BusAdr == held.adr && BusData == held.data &&
                        BusLast == held.last, "stall_hold", BusData, held.data);
                if (BusReady) begin
                    held_v = 0;
                    if (exp_q.size() == 0) begin
                        chk(0, "unexpected_beat", 64'(BusAdr), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(BusAdr == e.adr, "beat_adr", 64'(BusAdr), 64'(e.adr));
                        chk(BusData == e.data, "beat_data", BusData, e.data);
                        chk(BusLast == e.last, "beat_last", 64'(BusLast), 64'(e.last));
                        acc_cnt++;
                        if (e.last) m_valid = 0;
                    end
                end else begin
                    held_v = 1;
                    held.adr = BusAdr;
                    held.data = BusData;
                    held.last = BusLast;
                end
            end else begin
                held_v = 0;
            end
        end else begin
            prev_done = 0;
            held_v = 0;
        end
    end

    // Reference: lowest-index way that is both victim and dirty.
    task automatic capture(input logic [NW-1:0] vic, input logic [NW-1:0] dirty,
                           input logic [SL-1:0] set, output bit took);
        int sel;
        logic [LL-1:0] line;
        logic [TL-1:0] tag;
        logic [PA-1:0] base;
        beat_t b;
        sel = -1;
        for (int w = 0; w < NW; w++)
            if (sel < 0 && vic[w] && dirty[w]) sel = w;
        took = (sel >= 0);
        VictimWay = vic;
        DirtyWay = dirty;
        CacheSet = set;
        CaptureEn = 1'b1;
        tag = '0;
        if (took) begin
            line = ReadDataLineWay[sel*LL +: LL];
            tag = TagWay[sel*TL +: TL];
            base = (PA'(tag) << (SL + OL)) | (PA'(set) << OL);
            for (int k = 0; k < BEATS; k++) begin
                b.adr = base + PA'(k * (BL / 8));
                b.data = BL'(line >> (k * BL));
                b.last = (k == BEATS - 1);
                exp_q.push_back(b);
            end
        end
        @(posedge clk);
        if (took) begin
            m_valid = 1;
            m_id = {tag, set};
        end
        #1;
        CaptureEn = 1'b0;
        rand_ways();
        chk(BusValid == took, "capture_start", 64'(BusValid), 64'(took));
        chk(CaptureReady == !took, "capture_ready", 64'(CaptureReady), 64'(!took));
    endtask

    task automatic drain(input int mode, input bit poke);
        int start;
        int cyc;
        int r;
        start = done_cnt;
        cyc = 0;
        while (done_cnt == start && cyc < 200) begin
            case (mode)
                0: BusReady = 1'b1;
                1: BusReady = (cyc % 2 == 1);
                default: BusReady = 1'($urandom_range(0, 1));
            endcase
            CaptureEn = poke && (cyc == 1 || cyc == 2);
            if (CaptureEn) begin
                VictimWay = 4'b0001;
                DirtyWay = 4'b1111;
                rand_ways();
            end
            r = $urandom_range(0, 2);
            if (r == 0)
                LookupAdr = {m_id, 6'h38};
            else if (r == 1)
                LookupAdr = {m_id[PA-OL-1:SL], m_id[SL-1:0] ^ 7'h01, 6'h38};
            else
                LookupAdr = PA'({$urandom, $urandom});
            @(posedge clk);
            #1;
            cyc++;
        end
        chk(done_cnt != start, "drain_timeout", cyc, 200);
        BusReady = 1'b0;
        CaptureEn = 1'b0;
    endtask

    initial begin
        bit took;
        int a0;
        logic [BL-1:0] w2_lo;
        logic [NW-1:0] vic;
        int r;

        rand_ways();
        #1;
        chk(CaptureReady == 1'b1, "rst_capture_ready", 64'(CaptureReady), 1);
        chk(BusValid == 1'b0, "rst_bus_valid", 64'(BusValid), 0);
        chk(DrainDone == 1'b0, "rst_drain_done", 64'(DrainDone), 0);
        chk(BusLast == 1'b0, "rst_bus_last", 64'(BusLast), 0);
        chk(BusAdr == '0, "rst_bus_adr", 64'(BusAdr), 0);
        chk(BusData == '0, "rst_bus_data", BusData, 0);
        chk(BufferHit == 1'b0, "rst_hit", 64'(BufferHit), 0);
        #12 reset_n = 1'b1;
        @(posedge clk);
        #1;

        TagWay[2*TL +: TL] = TL'(22'h2A5A5);
        w2_lo = ReadDataLineWay[2*LL +: BL];
        capture(4'b0100, 4'b0100, 7'h15, took);
        chk(BusAdr == 34'h054B4A540, "first_adr", 64'(BusAdr), 64'h054B4A540);
        chk(BusData == w2_lo, "first_data", BusData, w2_lo);
        a0 = acc_cnt;
        drain(0, 0);
        chk(acc_cnt - a0 == BEATS, "beat_count", acc_cnt - a0, BEATS);

        capture(4'b0001, 4'b0011, 7'($urandom), took);
        drain(1, 1);

        capture(4'b0010, 4'b1101, 7'h22, took);
        @(posedge clk);
        #1;
        chk(BusValid == 1'b0 && CaptureReady == 1'b1, "clean_idle",
            {BusValid, CaptureReady}, 64'b01);
        capture(4'b0000, 4'b1111, 7'h33, took);
        capture(4'b0110, 4'b0110, 7'h44, took);
        drain(2, 1);

        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 4);
            vic = (r == 4) ? 4'b0000 : NW'(1 << r);
            capture(vic, NW'($urandom), 7'($urandom), took);
            if (took)
                drain($urandom_range(0, 2), 1'($urandom_range(0, 1)));
            else begin
                @(posedge clk);
                #1;
            end
        end

        capture(4'b1000, 4'b1000, 7'($urandom), took);
        BusReady = 1'b1;
        a0 = acc_cnt;
        for (int c = 0; c < 50 && acc_cnt - a0 < 3; c++) begin
            @(posedge clk);
            #1;
        end
        BusReady = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk(BusValid == 1'b0, "async_rst_valid", 64'(BusValid), 0);
        chk(CaptureReady == 1'b1, "async_rst_ready", 64'(CaptureReady), 1);
        chk(BufferHit == 1'b0, "async_rst_hit", 64'(BufferHit), 0);
        exp_q.delete();
        m_valid = 0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk(CaptureReady == 1'b1 && BusValid == 1'b0, "post_rst_idle",
            {CaptureReady, BusValid}, 64'b10);
        capture(4'b0100, 4'b0100, 7'($urandom), took);
        drain(2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
